// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the write-adapter FSM state type.
// The instruction-fetch read adapter imports the same constants.
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_XFER = 2'd1,
    WR_RESP = 2'd2,
    WR_ACK  = 2'd3
  } wr_state_e;
endpackage

// File: rtl/dmem_axi_write.sv
// Data-side store adapter: turns one CPU data-membus write into a single-beat
// AXI4 write (AW/W/B). One write is in flight at a time.
// Ports:
//   ACLK, ARESETN         clock, async active-low reset
//   dram_base             DRAM base added to the core address at acceptance
//   mem_*                 core request side (valid/ready, addr, wen, wdata,
//                         wstrb) and the one-cycle completion pulse mem_rvalid
//   M_AXI_AW*/W*/B*       AXI4 write master channels
//   err                   sticky: illegal request or bad B response
//   busy                  FSM not idle
module dmem_axi_write
  import axi_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,  // only 32 is supported
  parameter int AXI_ID     = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [31:0]             dram_base,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [31:0]             mem_addr,
  input  logic                    mem_wen,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic                    mem_rvalid,
  output logic [AXI_ID_W-1:0]     M_AXI_AWID,
  output logic [AXI_ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic [1:0]              M_AXI_AWLOCK,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic [3:0]              M_AXI_AWQOS,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [AXI_DATA_W-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [AXI_ID_W-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic                    err,
  output logic                    busy
);

  localparam logic [AXI_ID_W-1:0] ID_C = AXI_ID_W'(AXI_ID);

  wr_state_e                 state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_W-1:0]     addr_q, addr_d;
  logic [AXI_DATA_W-1:0]     wdata_q, wdata_d;
  logic [AXI_DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                      err_q, err_d;

  logic [31:0]               addr_sum;
  logic [AXI_ADDR_W-1:0]     addr_xl;
  logic                      aw_hs, w_hs;

  // 32-bit add wraps modulo 2^32, then fits to the AXI address width.
  assign addr_sum = dram_base + mem_addr;
  if (AXI_ADDR_W > 32) begin : g_zext
    assign addr_xl = {{(AXI_ADDR_W-32){1'b0}}, addr_sum};
  end else if (AXI_ADDR_W == 32) begin : g_same
    assign addr_xl = addr_sum;
  end else begin : g_trunc
    assign addr_xl = addr_sum[AXI_ADDR_W-1:0];
  end

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;

  // State and datapath registers. Async reset drops every valid at once,
  // abandoning any in-flight write (interconnect resets with us).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= WR_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      err_q     <= err_d;
    end
  end

  // Next state.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    err_d     = err_q;
    unique case (state_q)
      WR_IDLE: begin
        if (mem_valid) begin
          addr_d    = addr_xl;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!mem_wen) begin
            err_d   = 1'b1;
            state_d = WR_ACK;
          end else if (mem_wstrb == 4'b0000) begin
            state_d = WR_ACK;       // empty store: complete without a bus cycle
          end else begin
            state_d = WR_XFER;
          end
        end
      end
      WR_XFER: begin
        // AW and W complete independently; leave once both have.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != AXI_RESP_OKAY || M_AXI_BID != ID_C) err_d = 1'b1;
          state_d = WR_ACK;
        end
      end
      WR_ACK:  state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  // Outputs: all decoded from registers only, never from READY inputs.
  always_comb begin
    mem_ready     = (state_q == WR_IDLE);
    mem_rvalid    = (state_q == WR_ACK);
    busy          = (state_q != WR_IDLE);
    err           = err_q;
    M_AXI_AWVALID = (state_q == WR_XFER) && !aw_done_q;
    M_AXI_WVALID  = (state_q == WR_XFER) && !w_done_q;
    M_AXI_WLAST   = M_AXI_WVALID;
    M_AXI_BREADY  = (state_q == WR_RESP);
    M_AXI_AWADDR  = addr_q;
    M_AXI_AWADDR[1:0] = 2'b00;  // word-aligned; byte lanes come from WSTRB
    M_AXI_WDATA   = wdata_q;
    M_AXI_WSTRB   = wstrb_q;
    M_AXI_AWID    = ID_C;
    M_AXI_AWLEN   = 8'd0;
    M_AXI_AWSIZE  = AXI_SIZE_4B;
    M_AXI_AWBURST = AXI_BURST_INCR;
    M_AXI_AWLOCK  = 2'b00;
    M_AXI_AWCACHE = AXI_CACHE_BUF;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_AWQOS   = 4'b0000;
  end

endmodule

// File: tb/tb_dmem_axi_write.sv
module tb_dmem_axi_write;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] dram_base = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_rvalid;
  logic [0:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWQOS;
  logic        AWVALID;
  logic        AWREADY = 1'b1;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b1;
  logic [0:0]  BID = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic        BVALID = 1'b1;
  logic        BREADY;
  logic        err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  dmem_axi_write dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .dram_base(dram_base),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN),
    .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK),
    .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY), .err(err), .busy(busy)
  );

  // All tasks enter and leave 1ns after a rising edge.
  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    step();
  endtask

  // Present one request and return in the cycle after the accepting edge.
  task automatic send(input logic [31:0] base, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic wen);
    int g = 0;
    while (!mem_ready && g < 50) begin step(); g++; end
    if (!mem_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: mem_ready got 0 want 1");
    end
    dram_base = base; mem_addr = addr; mem_wdata = data;
    mem_wstrb = strb; mem_wen = wen; mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
  endtask

  // Cycles from acceptance to mem_rvalid (1 = first cycle after acceptance).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!mem_rvalid && lat < 50) begin step(); lat++; end
    if (!mem_rvalid) lat = -1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (mem_ready !== 1'b1) begin fails++; $display("FAIL rst_mem_ready: got %b want 1", mem_ready); end
    tests++; if (mem_rvalid !== 1'b0) begin fails++; $display("FAIL rst_mem_rvalid: got %b want 0", mem_rvalid); end
    tests++; if ({AWVALID, WVALID, BREADY} !== 3'b000) begin fails++; $display("FAIL rst_valids: got %b want 000", {AWVALID, WVALID, BREADY}); end
    tests++; if ({AWADDR, WDATA, WSTRB} !== 68'h0) begin fails++; $display("FAIL rst_data: got %h %h %h want 0", AWADDR, WDATA, WSTRB); end
    tests++; if ({err, busy} !== 2'b00) begin fails++; $display("FAIL rst_err_busy: got %b want 00", {err, busy}); end
    tests++; if ({AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS} !== {1'b0, 8'h00, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0})
      begin fails++; $display("FAIL rst_fixed_fields: got %h", {AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS}); end
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    send(32'h1000_0000, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1);
    tests++; if ({AWVALID, WVALID, WLAST} !== 3'b111) begin fails++; $display("FAIL basic_valids: got %b want 111", {AWVALID, WVALID, WLAST}); end
    tests++; if (AWADDR !== 32'h1000_0040) begin fails++; $display("FAIL basic_awaddr: got %h want 10000040", AWADDR); end
    tests++; if (WDATA !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_wdata: got %h want deadbeef", WDATA); end
    tests++; if (WSTRB !== 4'hF) begin fails++; $display("FAIL basic_wstrb: got %h want f", WSTRB); end
    tests++; if ({mem_ready, busy} !== 2'b01) begin fails++; $display("FAIL basic_ready_busy: got %b want 01", {mem_ready, busy}); end
    step();
    tests++; if ({AWVALID, WVALID, BREADY} !== 3'b001) begin fails++; $display("FAIL basic_resp_phase: got %b want 001", {AWVALID, WVALID, BREADY}); end
    wait_done(lat);
    lat++;  // one step was taken before waiting
    tests++; if (lat !== 3) begin fails++; $display("FAIL basic_latency: got %0d want 3", lat); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", err); end
    step();
    tests++; if ({mem_rvalid, mem_ready} !== 2'b01) begin fails++; $display("FAIL basic_after_ack: got %b want 01", {mem_rvalid, mem_ready}); end
  endtask

  task automatic test_aw_stall();
    int aw_hs = 0, w_hs = 0, rv = 0, rv_cyc = 0;
    AWREADY = 1'b0;
    send(32'h1000_0000, 32'h80, 32'h1234_5678, 4'hF, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) AWREADY = 1'b1;
      if (c <= 5) begin
        tests++; if (AWVALID !== 1'b1) begin fails++; $display("FAIL stall_awvalid_c%0d: got %b want 1", c, AWVALID); end
        tests++; if (AWADDR !== 32'h1000_0080) begin fails++; $display("FAIL stall_awaddr_c%0d: got %h want 10000080", c, AWADDR); end
      end
      if (c >= 2) begin
        tests++; if (WVALID !== 1'b0) begin fails++; $display("FAIL stall_wvalid_c%0d: got %b want 0", c, WVALID); end
      end
      if (AWVALID && AWREADY) aw_hs++;
      if (WVALID && WREADY) w_hs++;
      if (mem_rvalid) begin rv++; rv_cyc = c; end
      step();
    end
    tests++; if (aw_hs !== 1) begin fails++; $display("FAIL stall_aw_beats: got %0d want 1", aw_hs); end
    tests++; if (w_hs !== 1) begin fails++; $display("FAIL stall_w_beats: got %0d want 1", w_hs); end
    tests++; if (rv !== 1) begin fails++; $display("FAIL stall_rvalid_count: got %0d want 1", rv); end
    tests++; if (rv_cyc !== 7) begin fails++; $display("FAIL stall_rvalid_cycle: got %0d want 7", rv_cyc); end
  endtask

  task automatic test_noop_illegal();
    send(32'h1000_0000, 32'h10, 32'hAAAA_5555, 4'h0, 1'b1);
    tests++; if ({AWVALID, WVALID, mem_rvalid} !== 3'b001) begin fails++; $display("FAIL noop_cycle1: got %b want 001", {AWVALID, WVALID, mem_rvalid}); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL noop_err: got %b want 0", err); end
    step();
    send(32'h1000_0000, 32'h14, 32'hAAAA_5555, 4'hF, 1'b0);
    tests++; if ({AWVALID, WVALID, mem_rvalid} !== 3'b001) begin fails++; $display("FAIL illegal_cycle1: got %b want 001", {AWVALID, WVALID, mem_rvalid}); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err: got %b want 1", err); end
    step();
    apply_reset();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear_on_reset: got %b want 0", err); end
  endtask

  task automatic test_bresp_err();
    int lat;
    BRESP = 2'b10;
    send(32'h1000_0000, 32'h20, 32'h0, 4'hF, 1'b1);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL slverr_pre: got %b want 0", err); end
    wait_done(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL slverr_latency: got %0d want 3", lat); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL slverr_set: got %b want 1", err); end
    step();
    BRESP = 2'b00;
    for (int i = 0; i < 3; i++) begin
      send(32'h1000_0000, 32'h24 + 32'(4*i), 32'h0, 4'hF, 1'b1);
      wait_done(lat);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL slverr_sticky_%0d: got %b want 1", i, err); end
      step();
    end
    apply_reset();
    BID = 1'b1;
    send(32'h1000_0000, 32'h30, 32'h0, 4'hF, 1'b1);
    wait_done(lat);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL bid_mismatch_err: got %b want 1", err); end
    step();
    BID = 1'b0;
    apply_reset();
  endtask

  task automatic test_addr();
    int lat;
    send(32'hFFFF_FFF0, 32'h20, 32'h0BAD_F00D, 4'hF, 1'b1);
    tests++; if (AWADDR !== 32'h0000_0010) begin fails++; $display("FAIL addr_wrap: got %h want 00000010", AWADDR); end
    wait_done(lat);
    step();
    send(32'h1000_0000, 32'h43, 32'hCAFE_0000, 4'b0110, 1'b1);
    tests++; if (AWADDR !== 32'h1000_0040) begin fails++; $display("FAIL addr_align: got %h want 10000040", AWADDR); end
    tests++; if (WSTRB !== 4'b0110) begin fails++; $display("FAIL addr_wstrb: got %b want 0110", WSTRB); end
    wait_done(lat);
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    AWREADY = 1'b0;
    send(32'h1000_0000, 32'h50, 32'h5555_AAAA, 4'hF, 1'b1);
    tests++; if (AWVALID !== 1'b1) begin fails++; $display("FAIL midrst_pre_awvalid: got %b want 1", AWVALID); end
    #2 ARESETN = 1'b0;
    #1;
    tests++; if ({AWVALID, WVALID, BREADY} !== 3'b000) begin fails++; $display("FAIL midrst_async_drop: got %b want 000", {AWVALID, WVALID, BREADY}); end
    tests++; if ({mem_ready, busy} !== 2'b10) begin fails++; $display("FAIL midrst_idle: got %b want 10", {mem_ready, busy}); end
    AWREADY = 1'b1;
    @(negedge ACLK);
    ARESETN = 1'b1;
    step();
    tests++; if ({mem_ready, busy, AWVALID} !== 3'b100) begin fails++; $display("FAIL midrst_after_release: got %b want 100", {mem_ready, busy, AWVALID}); end
    send(32'h1000_0000, 32'h60, 32'h7777_8888, 4'hF, 1'b1);
    tests++; if (AWADDR !== 32'h1000_0060) begin fails++; $display("FAIL midrst_new_awaddr: got %h want 10000060", AWADDR); end
    wait_done(lat);
    tests++; if (lat !== 3) begin fails++; $display("FAIL midrst_new_latency: got %0d want 3", lat); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_stall();
    test_noop_illegal();
    test_bresp_err();
    test_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_axi_write.md
Name: dmem_axi_write

Overview:
- Data-side store adapter: takes single-word write requests from the CPU's data membus and issues single-beat AXI4 write transactions (AW/W/B) to DRAM.
- Sits beside the instruction-fetch read adapter, on the currently tied-off AXI write channel, downstream of the core's data port.
- Adds the boot-configured DRAM base to the core address.
- Allows one outstanding write and returns a one-cycle completion pulse to the core.

Parameters:
AXI_ID_W, 1, width of AWID/BID
AXI_ADDR_W, 32, AXI address width
AXI_DATA_W, 32, AXI data width; only 32 is supported
AXI_ID, 0, constant value driven on AWID and expected on BID

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
dram_base  in  32  DRAM base address, sampled at request acceptance
mem_valid  in  1  write request valid
mem_ready  out  1  block can accept a request
mem_addr  in  32  byte address, core view
mem_wen  in  1  must be 1 for requests to this block
mem_wdata  in  32  store data
mem_wstrb  in  4  byte enables
mem_rvalid  out  1  one-cycle write-complete pulse
M_AXI_AWID  out  AXI_ID_W  fixed AXI_ID
M_AXI_AWADDR  out  AXI_ADDR_W  translated address
M_AXI_AWLEN  out  8  fixed 0
M_AXI_AWSIZE  out  3  fixed 3'b010
M_AXI_AWBURST  out  2  fixed INCR (2'b01)
M_AXI_AWLOCK  out  2  fixed 0
M_AXI_AWCACHE  out  4  fixed 4'b0011
M_AXI_AWPROT  out  3  fixed 0
M_AXI_AWQOS  out  4  fixed 0
M_AXI_AWVALID  out  1  address valid
M_AXI_AWREADY  in  1  address ready
M_AXI_WDATA  out  AXI_DATA_W  store data
M_AXI_WSTRB  out  AXI_DATA_W/8  byte strobes
M_AXI_WLAST  out  1  equals WVALID (single beat)
M_AXI_WVALID  out  1  data valid
M_AXI_WREADY  in  1  data ready
M_AXI_BID  in  AXI_ID_W  response id
M_AXI_BRESP  in  2  response code
M_AXI_BVALID  in  1  response valid
M_AXI_BREADY  out  1  response ready
err  out  1  sticky error flag
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, ACLK; reset is asynchronous and active-low on ARESETN.
- Reset values:
  - state=IDLE, mem_ready=1, mem_rvalid=0.
  - AWVALID=WVALID=BREADY=0; AWADDR/WDATA/WSTRB=0.
  - err=0, busy=0.
- Reset mid-transaction: all valids drop immediately and the pending write is abandoned. The interconnect shares the same reset.
- FSM states: IDLE, XFER, RESP, ACK.
- IDLE:
  - mem_ready=1.
  - Accept on mem_valid & mem_ready. Latch addr_q = dram_base + mem_addr (32-bit add, wraps modulo 2^32, zero-extended/truncated to AXI_ADDR_W); latch wdata and wstrb.
  - mem_wen=0 on an accepted request: set err and go to ACK (no AXI traffic).
  - mem_wstrb==0: go to ACK (no-op, no AXI traffic).
  - Otherwise go to XFER.
  - AWADDR = addr_q with low 2 bits forced to 0.
- XFER:
  - AWVALID and WVALID both asserted from the first XFER cycle, concurrently.
  - Track aw_done/w_done. Each valid drops the cycle after its own handshake and stays low.
  - AWVALID/WVALID never depend on READY combinationally.
  - Once both handshakes are done (same cycle or different cycles), go to RESP.
- RESP:
  - BREADY=1.
  - On BVALID: if BRESP != OKAY (2'b00) or BID != AXI_ID, set err.
  - Go to ACK.
- ACK: mem_rvalid=1 for exactly one cycle, then IDLE.
- Latency: with READYs and BVALID all high, acceptance at cycle N gives AW/W handshake at N+1, B at N+2, mem_rvalid at N+3. The no-op/illegal path gives mem_rvalid at N+1.
- mem_ready is low from the cycle after acceptance until IDLE is re-entered; back-to-back throughput is one write per 4 cycles best case.
- err is sticky and clears only on reset.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00, AXI_CACHE_BUF=4'b0011.
  - Write FSM state typedef.
  - Reusable by the ifetch read adapter.
- No sub-module: a single FSM with two done flags.

Test Plan:
1. Base 0x1000_0000, write addr 0x40, data 0xDEADBEEF, strb 0xF, READYs=1, BVALID=1 -> AWADDR=0x1000_0040, WDATA=0xDEADBEEF, WLAST=1, mem_rvalid exactly 3 cycles after acceptance, err=0.
2. AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held stable with constant AWADDR until its handshake, single mem_rvalid, no duplicate beats.
3. Strb 0x0 -> no AWVALID/WVALID, mem_rvalid 1 cycle after acceptance; request with mem_wen=0 -> same timing plus err=1.
4. BRESP=2'b10 (SLVERR) -> err=1 after the B handshake and stays 1 through three later OKAY writes; BID mismatch also sets err.
5. Base 0xFFFF_FFF0 + addr 0x20 -> AWADDR=0x0000_0010 (wrap); mem_addr 0x43 -> AWADDR low bits forced to 0x40, WSTRB passed through unchanged.
6. Assert ARESETN low while in XFER with AWVALID=1 -> AWVALID/WVALID/BREADY go 0 without waiting for a clock edge; after release mem_ready=1, state=IDLE, and a new write completes normally.
